fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 21 ++
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fq_fifo.sv | 75 +++++++
 rtl/fetch_queue.sv | 78 +++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared CPU fetch definitions: instruction width, NOP encoding, default reset PC.
// Also holds the queue entry layout and the PC word-alignment helper.
// No logic; imported by the fetch queue, its FIFO and its interface.
package fetch_queue_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One queued fetch: the returned word and the address it was fetched from.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
  } fq_entry_t;

  // Force a fetch address onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: redirect, instruction-memory request/response, IF/ID head.
// master = fetch queue side, slave = core/memory environment side.
// Occupancy width tracks DEPTH so it can represent a completely full queue.
interface fetch_queue_if import fetch_queue_pkg::*; #(
  parameter int DEPTH = 4
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              imem_req;
  logic [31:0]       imem_addr;
  logic              imem_valid;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [31:0]       inst_pc;
  logic              id_stall;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    input  redirect, redirect_pc, imem_valid, imem_rdata, id_stall,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, occupancy
  );

  modport slave (
    output redirect, redirect_pc, imem_valid, imem_rdata, id_stall,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, occupancy
  );

endinterface

// File: rtl/fq_fifo.sv
// Circular buffer of fetch entries with head/tail pointers and a count.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is dropped when full unless a pop frees a slot that cycle.
module fq_fifo import fetch_queue_pkg::*; #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  localparam int         PTR_W    = $clog2(DEPTH),
  localparam int         CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  fq_entry_t        push_dat_i,
  input  logic             pop_i,
  output logic             head_vld_o,
  output fq_entry_t        head_dat_o,
  output logic [CNT_W-1:0] count_o
);

  fq_entry_t        mem_q [DEPTH];
  fq_entry_t        last_q;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);

  // While empty, keep presenting whatever was last shown so IF/ID sees no glitch.
  assign head_vld_o = ~empty;
  assign head_dat_o = empty ? last_q : mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Pointer/count next state; flush wins over any push or pop in the same cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  // Control state and the last-shown head value, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '{inst: NOP_INST, pc: RESET_PC};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      last_q   <= head_dat_o;
    end
  end

  // Entry storage; contents are only read once the count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between instruction memory and the IF/ID register.
// Latency: request at t, response written t+1, head visible t+2.
// Backpressure: id_stall holds the head; requests stop once held + in-flight reach DEPTH.
module fetch_queue import fetch_queue_pkg::*; #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic            clk,
  input logic            reset,
  fetch_queue_if.master  bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q;
  logic             pending_q;
  logic             squash_q;
  logic [OCC_W-1:0] count;
  logic [OCC_W:0]   committed;
  logic             req, push, pop, head_vld;
  fq_entry_t        head;
  fq_entry_t        push_dat;

  // Slots already spoken for: held entries plus last cycle's request still in flight.
  assign committed = {1'b0, count} + {{OCC_W{1'b0}}, pending_q};
  assign req       = reset & ~bus.redirect & (committed < (OCC_W + 1)'(DEPTH));

  // A response is dropped if it belongs to a request made before a redirect.
  assign push     = bus.imem_valid & ~squash_q;
  assign push_dat = '{inst: bus.imem_rdata, pc: req_pc_q};
  assign pop      = head_vld & ~bus.id_stall;

  // Next fetch address: redirect target (word aligned) or sequential advance.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect) fetch_pc_d = align_pc(bus.redirect_pc);
    else if (req)     fetch_pc_d = fetch_pc_q + 32'd4;
  end

  // Fetch PC, in-flight tracking and squash window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      pending_q  <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pending_q  <= req;
      squash_q   <= bus.redirect;
      if (req) req_pc_q <= fetch_pc_q;
    end
  end

  fq_fifo #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .flush_i    (bus.redirect),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_vld_o (head_vld),
    .head_dat_o (head),
    .count_o    (count)
  );

  assign bus.imem_req   = req;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = head_vld;
  assign bus.inst       = head.inst;
  assign bus.inst_pc    = head.pc;
  assign bus.occupancy  = count;

endmodule
